// File: rtl/mp64_mmio_arbiter.sv
// Round-robin arbiter funnelling per-core MMIO byte transactions to one slave port.
// Optional BUSY watchdog abort is compiled in with MP64_ARB_TIMEOUT_EN.
module mp64_mmio_arbiter #(
    parameter int NUM_CORES      = 4,
    parameter int CORE_ID_BITS   = 2,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_CORES-1:0]      core_req,
    input  logic [NUM_CORES*12-1:0]   core_addr,
    input  logic [NUM_CORES*8-1:0]    core_wdata,
    input  logic [NUM_CORES-1:0]      core_wen,
    output logic [NUM_CORES-1:0]      core_ack,
    output logic [7:0]                core_rdata,
    output logic                      mmio_req,
    output logic [11:0]               mmio_addr,
    output logic [7:0]                mmio_wdata,
    output logic                      mmio_wen,
    output logic [CORE_ID_BITS-1:0]   mmio_requester_id,
    input  logic [7:0]                mmio_rdata,
    input  logic                      mmio_ack,
    output logic                      bus_err
);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t                  state;
    logic [CORE_ID_BITS-1:0] last_grant;
    logic [CORE_ID_BITS-1:0] pick;
    logic [CORE_ID_BITS-1:0] cand;
    logic                    found;

`ifdef MP64_ARB_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ?
                           $clog2(TIMEOUT_CYCLES + 1) : 8;
    logic [CNT_W-1:0] cnt;
`else
    wire unused_timeout = |TIMEOUT_CYCLES;
    assign bus_err = 1'b0;
`endif

    // Search upward from the core after the last winner, wrapping modulo NUM_CORES.
    always_comb begin
        pick  = '0;
        cand  = '0;
        found = 1'b0;
        for (int i = 1; i <= NUM_CORES; i++) begin
            cand = CORE_ID_BITS'((int'(last_grant) + i) % NUM_CORES);
            if (!found && core_req[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state             <= IDLE;
            last_grant        <= CORE_ID_BITS'(NUM_CORES - 1);
            mmio_req          <= 1'b0;
            mmio_addr         <= '0;
            mmio_wdata        <= '0;
            mmio_wen          <= 1'b0;
            mmio_requester_id <= '0;
            core_ack          <= '0;
            core_rdata        <= '0;
`ifdef MP64_ARB_TIMEOUT_EN
            bus_err           <= 1'b0;
            cnt               <= '0;
`endif
        end else begin
            core_ack <= '0;
`ifdef MP64_ARB_TIMEOUT_EN
            bus_err  <= 1'b0;
`endif
            unique case (state)
                IDLE: begin
                    if (found) begin
                        mmio_req          <= 1'b1;
                        mmio_addr         <= core_addr[int'(pick)*12 +: 12];
                        mmio_wdata        <= core_wdata[int'(pick)*8 +: 8];
                        mmio_wen          <= core_wen[pick];
                        mmio_requester_id <= pick;
                        last_grant        <= pick;
                        state             <= BUSY;
`ifdef MP64_ARB_TIMEOUT_EN
                        cnt               <= '0;
`endif
                    end
                end
                BUSY: begin
                    if (mmio_ack) begin
                        mmio_req                    <= 1'b0;
                        core_rdata                  <= mmio_wen ? 8'h00 : mmio_rdata;
                        core_ack[mmio_requester_id] <= 1'b1;
                        state                       <= RESP;
                    end
`ifdef MP64_ARB_TIMEOUT_EN
                    else if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        mmio_req                    <= 1'b0;
                        core_rdata                  <= 8'hFF;
                        core_ack[mmio_requester_id] <= 1'b1;
                        bus_err                     <= 1'b1;
                        state                       <= RESP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
`endif
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mp64_mmio_arbiter.sv
// Bench for mp64_mmio_arbiter: directed scenarios plus random traffic
// against a transaction-schedule reference model.
module tb_mp64_mmio_arbiter;

    localparam int N  = 4;
    localparam int TO = 4;
`ifdef MP64_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    core_req;
    logic [N*12-1:0] core_addr;
    logic [N*8-1:0]  core_wdata;
    logic [N-1:0]    core_wen;
    logic [N-1:0]    core_ack;
    logic [7:0]      core_rdata;
    logic            mmio_req;
    logic [11:0]     mmio_addr;
    logic [7:0]      mmio_wdata;
    logic            mmio_wen;
    logic [1:0]      mmio_requester_id;
    logic [7:0]      mmio_rdata;
    logic            mmio_ack;
    logic            bus_err;

    mp64_mmio_arbiter #(
        .NUM_CORES(N), .CORE_ID_BITS(2), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .core_req(core_req), .core_addr(core_addr),
        .core_wdata(core_wdata), .core_wen(core_wen),
        .core_ack(core_ack), .core_rdata(core_rdata),
        .mmio_req(mmio_req), .mmio_addr(mmio_addr),
        .mmio_wdata(mmio_wdata), .mmio_wen(mmio_wen),
        .mmio_requester_id(mmio_requester_id),
        .mmio_rdata(mmio_rdata), .mmio_ack(mmio_ack),
        .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: one scheduled grant at a time, expressed as cycle numbers.
    int         ptr;
    int         next_arb;
    int         g_a, g_w, g_id;
    logic [11:0] g_addr;
    logic [7:0]  g_wd, g_rd;
    logic        g_wen, g_to;
    logic [7:0]  exp_rdata;
    int         force_w  = -1;
    int         force_rd = -1;
    int         rise_id[$];
    int         rise_cyc[$];
    bit         prev_mreq;
    int         buserr_seen = 0;
    int         checks = 0;
    int         failures = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int rr_pick(input logic [N-1:0] r, input int p);
        for (int i = 1; i <= N; i++)
            if (r[(p + i) % N]) return (p + i) % N;
        return -1;
    endfunction

    task automatic issue(input int c, input logic [11:0] a, input logic [7:0] d, input logic w);
        core_req[c]           = 1'b1;
        core_addr[c*12 +: 12] = a;
        core_wdata[c*8 +: 8]  = d;
        core_wen[c]           = w;
    endtask

    task automatic arbitrate();
        int w;
        if (cyc + 1 >= next_arb && core_req != '0) begin
            g_id   = rr_pick(core_req, ptr);
            ptr    = g_id;
            g_a    = cyc + 1;
            w      = (force_w >= 0) ? force_w : int'($urandom_range(0, TO_EN ? 5 : 3));
            g_to   = TO_EN && (w >= TO);
            g_w    = g_to ? TO - 1 : w;
            g_rd   = (force_rd >= 0) ? 8'(force_rd) : 8'($urandom);
            g_addr = core_addr[g_id*12 +: 12];
            g_wd   = core_wdata[g_id*8 +: 8];
            g_wen  = core_wen[g_id];
            next_arb = g_a + g_w + 3;
        end
    endtask

    task automatic check_outputs();
        int         ack_c;
        bit         in_req;
        logic [N-1:0] ea;
        ack_c  = g_a + g_w + 1;
        in_req = (cyc >= g_a) && (cyc <= g_a + g_w);
        chk("mmio_req", mmio_req, in_req);
        if (in_req) begin
            chk("mmio_requester_id", mmio_requester_id, g_id);
            chk("mmio_addr", mmio_addr, g_addr);
            chk("mmio_wdata", mmio_wdata, g_wd);
            chk("mmio_wen", mmio_wen, g_wen);
        end
        if (cyc == ack_c)
            exp_rdata = g_to ? 8'hFF : (g_wen ? 8'h00 : g_rd);
        ea = '0;
        if (cyc == ack_c) ea[g_id] = 1'b1;
        chk("core_ack", core_ack, ea);
        chk("core_rdata", core_rdata, exp_rdata);
        chk("bus_err", bus_err, (cyc == ack_c) && g_to);
        if (bus_err === 1'b1) buserr_seen++;
        if (mmio_req === 1'b1 && !prev_mreq) begin
            rise_id.push_back(int'(mmio_requester_id));
            rise_cyc.push_back(cyc);
        end
        prev_mreq = (mmio_req === 1'b1);
    endtask

    task automatic step(input bit rnd);
        int drop;
        drop = -1;
        arbitrate();
        @(negedge clk);
        check_outputs();
        if (cyc == g_a + g_w + 1) begin
            core_req[g_id] = 1'b0;
            drop = g_id;
        end
        if (rnd)
            for (int c = 0; c < N; c++)
                if (!core_req[c] && c != drop && $urandom_range(0, 3) == 0)
                    issue(c, 12'($urandom), 8'($urandom), 1'($urandom));
        mmio_ack   = (cyc == g_a + g_w) && !g_to;
        mmio_rdata = mmio_ack ? g_rd : 8'($urandom);
    endtask

    task automatic run(input int n);
        repeat (n) step(1'b0);
    endtask

    task automatic apply_reset();
        rst_n     = 1'b0;
        core_req  = '0;
        mmio_ack  = 1'b0;
        g_a       = -100;
        g_w       = 0;
        g_to      = 1'b0;
        ptr       = N - 1;
        exp_rdata = 8'h00;
        prev_mreq = 1'b0;
        #1;
        chk("rst_mmio_req", mmio_req, 1'b0);
        chk("rst_mmio_addr", mmio_addr, 12'h000);
        chk("rst_mmio_wdata", mmio_wdata, 8'h00);
        chk("rst_mmio_wen", mmio_wen, 1'b0);
        chk("rst_requester_id", mmio_requester_id, 2'd0);
        chk("rst_core_ack", core_ack, 4'b0000);
        chk("rst_core_rdata", core_rdata, 8'h00);
        chk("rst_bus_err", bus_err, 1'b0);
        repeat (2) @(negedge clk);
        rst_n    = 1'b1;
        next_arb = cyc + 1;
    endtask

    task automatic clear_log();
        rise_id.delete();
        rise_cyc.delete();
    endtask

    function automatic int rid(input int i);
        return (i < rise_id.size()) ? rise_id[i] : -1;
    endfunction

    initial begin
        rst_n = 1'b1; core_req = '0; core_addr = '0; core_wdata = '0;
        core_wen = '0; mmio_ack = 1'b0; mmio_rdata = 8'h00;
        #1 apply_reset();

        // Core 1 reads 0x508 from a zero-wait slave returning 0x05
        force_w = 0; force_rd = 8'h05; clear_log();
        issue(1, 12'h508, 8'h00, 1'b0);
        run(5);
        chk("t1_id", rid(0), 1);
        chk("t1_rises", rise_id.size(), 1);
        chk("t1_rdata", core_rdata, 8'h05);

        // All four cores together after reset
        apply_reset(); clear_log(); force_rd = -1;
        for (int c = 0; c < N; c++) issue(c, 12'(12'h100 + c), 8'(c), 1'b0);
        run(14);
        chk("t2_count", rise_id.size(), 4);
        for (int i = 0; i < 4; i++) chk($sformatf("t2_order%0d", i), rid(i), i);
        for (int i = 1; i < 4; i++)
            chk($sformatf("t2_gap%0d", i),
                (i < rise_cyc.size()) ? rise_cyc[i] - rise_cyc[i-1] : -1, 3);

        // Fairness after core 2
        clear_log();
        issue(2, 12'h222, 8'h22, 1'b0); run(5);
        issue(0, 12'h010, 8'h01, 1'b0); issue(3, 12'h030, 8'h03, 1'b1); run(8);
        issue(0, 12'h011, 8'h02, 1'b0); run(5);
        chk("t3_g0", rid(0), 2);
        chk("t3_g1", rid(1), 3);
        chk("t3_g2", rid(2), 0);
        chk("t3_g3", rid(3), 0);

        // Spinlock acquire by core 0 while core 1 keeps requesting
        clear_log(); force_rd = 8'h01;
        issue(0, 12'h600, 8'h00, 1'b0); run(1);
        issue(1, 12'h604, 8'h00, 1'b0); run(8);
        chk("t4_rises", rise_id.size(), 2);
        chk("t4_first", rid(0), 0);
        chk("t4_second", rid(1), 1);

        // Write from core 3; returned slave byte must not leak into rdata
        clear_log(); force_rd = 8'hA5;
        issue(3, 12'h509, 8'h00, 1'b1); run(5);
        chk("t5_id", rid(0), 3);
        chk("t5_rdata", core_rdata, 8'h00);

        // Random traffic with random slave wait states
        force_w = -1; force_rd = -1;
        repeat (300) step(1'b1);
        run(40);

        // Reset in the middle of BUSY
        force_w = 5; clear_log();
        issue(1, 12'h123, 8'h00, 1'b0); run(2);
        chk("t6_busy", rise_id.size(), 1);
        #2 apply_reset();
        run(6);

`ifdef MP64_ARB_TIMEOUT_EN
        // Slave never answers
        force_w = 50; buserr_seen = 0;
        issue(2, 12'h700, 8'h00, 1'b0); run(8);
        chk("t7_rdata", core_rdata, 8'hFF);
        chk("t7_buserr_pulses", buserr_seen, 1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
